// File: rtl/cache_pkg.sv
`default_nettype none
//============================================================================
// Module   : cache_pkg
// Brief    : Shared state encoding, byte-lane word type and merge helper
//            for the direct-mapped data cache.
// Revision : 1.0
//============================================================================
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WB         = 3'd1,
        FILL       = 3'd2,
        RESP       = 3'd3,
        FLUSH_SCAN = 3'd4,
        FLUSH_WB   = 3'd5,
        DONE       = 3'd6
    } state_t;

    // Element i is the byte at word address + i.
    typedef logic [0:3][7:0] byte_word_t;

    function automatic byte_word_t merge_bytes(input byte_word_t base,
                                               input byte_word_t wdata,
                                               input logic [3:0] ben);
        byte_word_t res;
        res = base;
        for (int i = 0; i < 4; i++) begin
            if (ben[i]) begin
                res[i] = wdata[i];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
//============================================================================
// Module   : data_cache_if
// Brief    : Core load/store request bus between mips_core and data_cache.
// Revision : 1.0
//============================================================================
interface data_cache_if import cache_pkg::*; ();

    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    byte_word_t  req_wdata;
    logic [3:0]  req_ben;
    logic        req_ready;
    byte_word_t  req_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_ben,
        input  req_ready, req_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_ben,
        output req_ready, req_rdata
    );

endinterface
`default_nettype wire

// File: rtl/data_cache_array.sv
`default_nettype none
//============================================================================
// Module   : data_cache_array
// Brief    : Tag/valid/dirty/data line storage, one async read port and one
//            write port; valid/dirty cleared asynchronously on reset.
// Revision : 1.0
//============================================================================
module data_cache_array import cache_pkg::*; #(
    parameter int LINES = 64,
    parameter int TAG_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [$clog2(LINES)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_W-1:0]         rd_tag,
    output byte_word_t               rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_idx,
    input  logic                     wr_valid,
    input  logic                     wr_dirty,
    input  logic [TAG_W-1:0]         wr_tag,
    input  byte_word_t               wr_data
);

    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;
    logic [TAG_W-1:0] r_tag  [LINES];
    byte_word_t       r_data [LINES];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= wr_valid;
            r_dirty[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data payload carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_dirty = r_dirty[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
//============================================================================
// Module   : data_cache
// Brief    : Direct-mapped write-back write-allocate data cache with flush
//            sequencing in front of a fixed-latency byte-lane memory.
// Revision : 1.0
//============================================================================
module data_cache import cache_pkg::*; #(
    parameter int LINES       = 64,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    data_cache_if.slave core,
    input  logic        flush_req,
    output logic        flush_done,
    output logic [31:0] mem_addr,
    output byte_word_t  mem_data_in,
    input  byte_word_t  mem_data_out,
    output logic        mem_write_en
);

    localparam int C_IDX_W = $clog2(LINES);
    localparam int C_TAG_W = 30 - C_IDX_W;
    localparam int C_CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(MEM_LATENCY - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(LINES - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_ONE  = C_IDX_W'(1);

    state_t               r_state, w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [C_IDX_W-1:0]   r_fidx, w_fidx_nxt;
    logic [C_IDX_W-1:0]   w_req_idx, w_rd_idx;
    logic [C_TAG_W-1:0]   w_req_tag, w_rd_tag, w_wr_tag;
    logic                 w_rd_valid, w_rd_dirty, w_hit, w_cnt_last;
    logic                 w_wr_en, w_wr_valid, w_wr_dirty;
    logic                 w_unused;
    byte_word_t           w_rd_data, w_wr_data;

    assign w_req_idx  = core.req_addr[C_IDX_W+1:2];
    assign w_req_tag  = core.req_addr[31:C_IDX_W+2];
    assign w_unused   = ^core.req_addr[1:0];
    assign w_rd_idx   = (r_state == FLUSH_SCAN || r_state == FLUSH_WB) ? r_fidx : w_req_idx;
    assign w_hit      = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    data_cache_array #(
        .LINES (LINES),
        .TAG_W (C_TAG_W)
    ) u_array (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_idx   (w_rd_idx),
        .rd_valid (w_rd_valid),
        .rd_dirty (w_rd_dirty),
        .rd_tag   (w_rd_tag),
        .rd_data  (w_rd_data),
        .wr_en    (w_wr_en),
        .wr_idx   (w_rd_idx),
        .wr_valid (w_wr_valid),
        .wr_dirty (w_wr_dirty),
        .wr_tag   (w_wr_tag),
        .wr_data  (w_wr_data)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_fidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fidx  <= w_fidx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_fidx_nxt     = r_fidx;
        core.req_ready = 1'b0;
        core.req_rdata = '0;
        flush_done     = 1'b0;
        mem_addr       = '0;
        mem_data_in    = '0;
        mem_write_en   = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_valid     = w_rd_valid;
        w_wr_dirty     = w_rd_dirty;
        w_wr_tag       = w_rd_tag;
        w_wr_data      = w_rd_data;

        case (r_state)
            IDLE: begin
                if (flush_req) begin
                    w_state_nxt = FLUSH_SCAN;
                    w_fidx_nxt  = '0;
                end else if (core.req_valid) begin
                    if (w_hit) begin
                        core.req_ready = 1'b1;
                        if (core.req_write) begin
                            w_wr_en    = 1'b1;
                            w_wr_dirty = 1'b1;
                            w_wr_data  = merge_bytes(w_rd_data, core.req_wdata, core.req_ben);
                        end else begin
                            core.req_rdata = w_rd_data;
                        end
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_rd_valid && w_rd_dirty) ? WB : FILL;
                    end
                end
            end

            WB: begin
                mem_addr     = {w_rd_tag, w_req_idx, 2'b00};
                mem_data_in  = w_rd_data;
                mem_write_en = (r_cnt == '0);
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = FILL;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            FILL: begin
                mem_addr = {core.req_addr[31:2], 2'b00};
                if (w_cnt_last) begin
                    // Line is installed on the sampling edge; RESP reads it back.
                    w_wr_en     = 1'b1;
                    w_wr_valid  = 1'b1;
                    w_wr_tag    = w_req_tag;
                    w_wr_dirty  = core.req_write;
                    w_wr_data   = core.req_write ?
                                  merge_bytes(mem_data_out, core.req_wdata, core.req_ben) :
                                  mem_data_out;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            RESP: begin
                core.req_ready = 1'b1;
                if (!core.req_write) begin
                    core.req_rdata = w_rd_data;
                end
                w_state_nxt = IDLE;
            end

            FLUSH_SCAN: begin
                if (w_rd_valid && w_rd_dirty) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = FLUSH_WB;
                end else if (r_fidx == C_IDX_LAST) begin
                    w_state_nxt = DONE;
                end else begin
                    w_fidx_nxt = r_fidx + C_IDX_ONE;
                end
            end

            FLUSH_WB: begin
                mem_addr     = {w_rd_tag, r_fidx, 2'b00};
                mem_data_in  = w_rd_data;
                mem_write_en = (r_cnt == '0);
                if (w_cnt_last) begin
                    w_wr_en    = 1'b1;
                    w_wr_dirty = 1'b0;
                    if (r_fidx == C_IDX_LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_fidx_nxt  = r_fidx + C_IDX_ONE;
                        w_state_nxt = FLUSH_SCAN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            DONE: begin
                flush_done = 1'b1;
                if (!flush_req) begin
                    w_state_nxt = IDLE;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
//============================================================================
// Module   : tb_data_cache
// Brief    : Scoreboard bench for data_cache against a flat-memory model.
// Revision : 1.0
//============================================================================
module tb_data_cache;
    import cache_pkg::*;

    localparam int LINES = 64;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic [31:0] mem_addr;
    byte_word_t  mem_data_in;
    byte_word_t  mem_data_out = '0;
    logic        mem_write_en;

    data_cache_if bus ();

    data_cache #(.LINES(LINES), .MEM_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .core         (bus),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- backing memory ----------------
    byte_word_t  mem [logic [31:0]];
    int          stab = 0;
    logic [31:0] last_addr = '1;

    function automatic byte_word_t init_word(input logic [31:0] a);
        byte_word_t w;
        if (a == 32'h10) w = {8'h11, 8'h22, 8'h33, 8'h44};
        else             w = {a[9:2] ^ 8'h5A, a[9:2] + 8'd1, 8'hC3, a[7:0]};
        return w;
    endfunction

    function automatic byte_word_t mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    // Data appears only once the address has been held for LAT cycles.
    always @(negedge clk) begin
        if (mem_write_en) mem[mem_addr] = mem_data_in;
        if (mem_addr == last_addr) stab++;
        else                       stab = 1;
        last_addr = mem_addr;
        mem_data_out <= (stab >= LAT) ? mem_rd(mem_addr) : {4{8'hEE}};
    end

    // ---------------- reference model ----------------
    byte_word_t  ref_mem [logic [31:0]];
    logic [31:0] m_addr  [LINES];
    bit          m_valid [LINES];
    bit          m_dirty [LINES];

    typedef struct { bit is_write; byte_word_t rdata; int unsigned cyc; } exp_t;
    typedef struct { logic [31:0] addr; byte_word_t data; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    function automatic byte_word_t ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic int model_access(input bit wr, input logic [31:0] addr,
                                        input byte_word_t wd, input logic [3:0] ben,
                                        output byte_word_t rd);
        logic [31:0] wa;
        int          idx;
        int          lat;
        byte_word_t  nw;
        wa  = {addr[31:2], 2'b00};
        idx = int'((wa >> 2) % LINES);
        if (m_valid[idx] && m_addr[idx] == wa) begin
            lat = 0;
        end else begin
            if (m_valid[idx] && m_dirty[idx]) begin
                wr_q.push_back('{m_addr[idx], ref_rd(m_addr[idx])});
                lat = 2 * LAT + 1;
            end else begin
                lat = LAT + 1;
            end
            m_valid[idx] = 1'b1;
            m_addr[idx]  = wa;
            m_dirty[idx] = 1'b0;
        end
        rd = ref_rd(wa);
        if (wr) begin
            nw = rd;
            for (int i = 0; i < 4; i++) if (ben[i]) nw[i] = wd[i];
            ref_mem[wa]  = nw;
            m_dirty[idx] = 1'b1;
        end
        return lat;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (rst_b) begin
            if (bus.req_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 1'b0, $sformatf("req_ready=1 at cycle %0d, none expected", cyc));
                end else begin
                    e = exp_q.pop_front();
                    check("ready_cycle", cyc == e.cyc, $sformatf("got cycle %0d want %0d", cyc, e.cyc));
                    if (!e.is_write)
                        check("rdata", bus.req_rdata == e.rdata,
                              $sformatf("got %h want %h", bus.req_rdata, e.rdata));
                end
            end
            if (mem_write_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1'b0, $sformatf("mem_write_en=1 addr %h, none expected", mem_addr));
                end else begin
                    w = wr_q.pop_front();
                    check("wb_addr", mem_addr == w.addr, $sformatf("got %h want %h", mem_addr, w.addr));
                    check("wb_data", mem_data_in == w.data, $sformatf("got %h want %h", mem_data_in, w.data));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 1'b0, "req_ready got 0 for 100 cycles want 1");
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input bit wr, input logic [31:0] addr,
                             input byte_word_t wd, input logic [3:0] ben);
        byte_word_t rd;
        int         lat;
        lat = model_access(wr, addr, wd, ben, rd);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_ben   = ben;
        exp_q.push_back('{wr, rd, cyc + lat});
        wait_ready("access");
        bus.req_valid = 1'b0;
    endtask

    task automatic do_flush(input bit with_req, input logic [31:0] addr);
        int          nd;
        int unsigned c0;
        bit          seen;
        byte_word_t  rd;
        int          lat;
        nd = 0;
        for (int i = 0; i < LINES; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                wr_q.push_back('{m_addr[i], ref_rd(m_addr[i])});
                m_dirty[i] = 1'b0;
                nd++;
            end
        end
        flush_req = 1'b1;
        if (with_req) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_addr  = addr;
            bus.req_ben   = 4'h0;
        end
        c0   = cyc;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (flush_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("flush_done_cycle", seen && cyc == c0 + LINES + 1 + nd * LAT,
              $sformatf("got seen=%0d cycle %0d want cycle %0d", seen, cyc - c0, LINES + 1 + nd * LAT));
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        if (with_req) begin
            lat = model_access(1'b0, addr, '0, 4'h0, rd);
            exp_q.push_back('{1'b0, rd, cyc + 1 + lat});
            wait_ready("flush_held_req");
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
        check("flush_done_drop", flush_done == 1'b0, $sformatf("got %0d want 0", flush_done));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_word_t  wd;
        logic [31:0] a;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_addr[i]  = '0;
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_ben   = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;
        check("rst_req_ready",  bus.req_ready == 1'b0, $sformatf("got %0d want 0", bus.req_ready));
        check("rst_flush_done", flush_done == 1'b0,    $sformatf("got %0d want 0", flush_done));
        check("rst_mem_we",     mem_write_en == 1'b0,  $sformatf("got %0d want 0", mem_write_en));
        check("rst_mem_addr",   mem_addr == 32'h0,     $sformatf("got %h want 0", mem_addr));
        check("rst_mem_din",    mem_data_in == '0,     $sformatf("got %h want 0", mem_data_in));
        check("rst_rdata",      bus.req_rdata == '0,   $sformatf("got %h want 0", bus.req_rdata));
        @(posedge clk);
        #1;

        // Directed sequence around word 0x10 / index 4 and index 9.
        do_access(1'b0, 32'h10, '0, 4'h0);
        do_access(1'b0, 32'h10, '0, 4'h0);
        wd = '0;
        wd[0] = 8'hAA;
        do_access(1'b1, 32'h10, wd, 4'b0001);
        do_access(1'b0, 32'h10, '0, 4'h0);
        do_access(1'b0, 32'h110, '0, 4'h0);
        do_access(1'b1, 32'h10, byte_word_t'($urandom), 4'hF);
        do_access(1'b1, 32'h24, byte_word_t'($urandom), 4'h3);
        do_flush(1'b1, 32'h10);

        // Random traffic over 4 tags x 8 indices to force hits and conflicts.
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(1, 4)) * LINES * 4 + 32'($urandom_range(0, 7)) * 4
                + 32'($urandom_range(0, 3));
            do_access(1'($urandom_range(0, 1)), a, byte_word_t'($urandom), 4'($urandom));
        end
        do_flush(1'b0, 32'h0);

        for (int t = 1; t <= 4; t++) begin
            for (int i = 0; i < 8; i++) begin
                a = 32'(t * LINES * 4 + i * 4);
                check("mem_final", mem_rd(a) == ref_rd(a),
                      $sformatf("addr %h got %h want %h", a, mem_rd(a), ref_rd(a)));
            end
        end
        check("mem_final_10", mem_rd(32'h10) == ref_rd(32'h10),
              $sformatf("got %h want %h", mem_rd(32'h10), ref_rd(32'h10)));
        check("queues_drained", exp_q.size() == 0 && wr_q.size() == 0,
              $sformatf("got exp=%0d wr=%0d want 0/0", exp_q.size(), wr_q.size()));

        // Reset in the second FILL cycle of a miss.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h8000;
        bus.req_ben   = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("fill_addr", mem_addr == 32'h8000, $sformatf("got %h want 00008000", mem_addr));
        #1;
        rst_b = 1'b0;
        #1;
        check("midrst_req_ready", bus.req_ready == 1'b0, $sformatf("got %0d want 0", bus.req_ready));
        check("midrst_mem_addr",  mem_addr == 32'h0,     $sformatf("got %h want 0", mem_addr));
        check("midrst_mem_we",    mem_write_en == 1'b0,  $sformatf("got %0d want 0", mem_write_en));
        check("midrst_mem_din",   mem_data_in == '0,     $sformatf("got %h want 0", mem_data_in));
        check("midrst_rdata",     bus.req_rdata == '0,   $sformatf("got %h want 0", bus.req_rdata));
        bus.req_valid = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b0, 32'h10, '0, 4'h0);
        do_access(1'b0, 32'h10, '0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
